pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch-PC controller for the 5-stage LEGv8 pipeline. Owns the PC register and selects the next fetch address.
//  - Sources: sequential PC+4, hazard-unit stall, branch redirect at resolution.
//  - Consumes the 64-bit sign-extended word offsets (B/BL, CBZ/CBNZ) produced in decode.
//  - Drives per-stage flush strobes and branch/mispredict event counters.
// PARAMETERS
//  RESET_PC   64'h0  fetch address loaded by reset
//  CNT_W      32     width of br_count / mispred_count
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      synchronous, active-low reset
//  stall          in   1      load-use hazard: hold PC
//  br_valid       in   1      branch resolving this cycle (EX/MEM)
//  br_uncond      in   1      resolving branch is B/BL
//  br_cbz         in   1      resolving branch is CBZ
//  br_cbnz        in   1      resolving branch is CBNZ
//  br_zero        in   1      ALU zero flag of resolving branch
//  br_pred        in   1      prediction carried with branch (ignored without macro)
//  br_pc          in   64     PC of resolving branch
//  br_imm         in   64     sign-extended word offset of resolving branch
//  id_valid       in   1      decode-stage instruction valid
//  id_is_cb       in   1      decode instruction is CBZ/CBNZ
//  id_pc          in   64     PC of decode instruction
//  id_imm         in   64     sign-extended word offset in decode
//  pc             out  64     current fetch PC (registered)
//  fetch_valid    out  1      fetch address is valid (registered)
//  id_pred_taken  out  1      prediction for decode instruction (comb.)
//  flush          out  3      {EX/MEM, ID/EX, IF/ID} squash strobes (comb.)
//  br_count       out  CNT_W  resolved branches (registered, saturating)
//  mispred_count  out  CNT_W  resolve-stage redirects (registered, saturating)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pc=RESET_PC, fetch_valid=0, counters=0, state=BOOT. flush=0 and id_pred_taken=0 while rst_n=0.
//  - FSM: BOOT -> RUN after one cycle (fetch_valid=0 in BOOT, 1 in RUN, pc held in BOOT). RUN has no exit except reset.
//  - taken = br_uncond | (br_cbz & br_zero) | (br_cbnz & ~br_zero).
//  - mis = br_valid & (taken != pred); pred = br_pred with macro, else 0.
//  - Targets: {imm[61:0],2'b00} added to base. All adds are mod 2^64, wrap silently.
//  - Next-PC priority in RUN, one of these per cycle:
//    1. mis: pc <= taken ? br_pc+(br_imm<<2) : br_pc+4; flush=3'b111 same cycle.
//    2. stall: pc held, flush=0.
//    3. id_pred_taken: pc <= id_pc+(id_imm<<2); flush=3'b001.
//    4. else pc <= pc+4.
//  - Redirect latency: one edge; the new pc is visible the cycle after the causing inputs.
//  - Resolution overrides a simultaneous stall and a simultaneous decode prediction.
//  - Counters: br_count +1 per br_valid cycle; mispred_count +1 per mis cycle. Both saturate at all-ones and are frozen in BOOT.
//  - br_valid in BOOT is ignored. Reset mid-redirect discards the target; pc=RESET_PC.
// CONFIGURATION
//  STATIC_BTFN_PREDICT_EN defined:
//    - id_pred_taken = id_valid & id_is_cb & id_imm[63] & ~stall & ~mis (backward-taken / forward-not-taken).
//    - br_pred is honoured, so a correctly predicted taken CB causes no resolve redirect.
//  Undefined:
//    - id_pred_taken tied 0, br_pred ignored.
//    - Every taken branch redirects at resolution; not-taken branches never redirect.
// TESTING
//  1. Reset: rst_n low 2 cycles, release -> pc=RESET_PC, fetch_valid=0 one cycle, then 1; pc +4 per cycle.
//  2. B: br_valid,br_uncond, br_pc=0x100, br_imm=-2 -> flush=111 that cycle, next pc=0xF8, mispred_count=1.
//  3. CBZ: br_zero=0, br_pc=0x40 -> no flush, pc continues +4, br_count=1, mispred_count=0.
//  4. stall=1 for 3 cycles at pc=0x20 -> pc stays 0x20. stall+mis in the same cycle -> redirect taken, flush=111.
//  5. Macro on, part 1: id CBNZ id_pc=0x80, id_imm=-4 -> id_pred_taken=1, flush=001, next pc=0x70.
//  6. Macro on, part 2: that CBNZ resolves br_zero=1 with br_pred=1 -> next pc=0x84, flush=111.
//  7. Saturation: counters preloaded near max -> mispred_count holds all-ones.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-PC controller for the 5-stage LEGv8 pipeline
//
// Owns the PC register and picks the next fetch address from PC+4, a
// hazard stall, a decode-stage static prediction or a resolve-stage redirect.
// It also drives the per-stage flush strobes and the saturating branch and
// mispredict counters.
//
// Optional feature: define STATIC_BTFN_PREDICT_EN to enable backward-taken /
// forward-not-taken prediction of CBZ/CBNZ in decode and to honour br_pred at
// resolution. Without the macro, id_pred_taken is 0 and br_pred is ignored.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   stall               load-use hazard, hold PC
//   br_valid            branch resolving this cycle
//   br_uncond/cbz/cbnz  kind of the resolving branch
//   br_zero             ALU zero flag of the resolving branch
//   br_pred             prediction carried with the resolving branch
//   br_pc, br_imm       PC and sign-extended word offset of the resolving branch
//   id_valid, id_is_cb  decode instruction valid / is CBZ or CBNZ
//   id_pc, id_imm       PC and sign-extended word offset in decode
//   pc, fetch_valid     registered fetch address and its valid
//   id_pred_taken       prediction for the decode instruction (comb.)
//   flush               {EX/MEM, ID/EX, IF/ID} squash strobes (comb.)
//   br_count            resolved branches (saturating)
//   mispred_count       resolve-stage redirects (saturating)
module pc_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             br_uncond,
    input  logic             br_cbz,
    input  logic             br_cbnz,
    input  logic             br_zero,
    input  logic             br_pred,
    input  logic [63:0]      br_pc,
    input  logic [63:0]      br_imm,
    input  logic             id_valid,
    input  logic             id_is_cb,
    input  logic [63:0]      id_pc,
    input  logic [63:0]      id_imm,
    output logic [63:0]      pc,
    output logic             fetch_valid,
    output logic             id_pred_taken,
    output logic [2:0]       flush,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    typedef enum logic {BOOT, RUN} state_t;

    state_t           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
    logic             run, taken, pred, mis, idp;
    logic [63:0]      br_tgt, id_tgt;

    // Comb outputs stay quiet during reset and BOOT.
    assign run    = rst_n & (state_q == RUN);
    assign taken  = br_uncond | (br_cbz & br_zero) | (br_cbnz & ~br_zero);
    assign mis    = run & br_valid & (taken != pred);
    assign br_tgt = br_pc + {br_imm[61:0], 2'b00};
    assign id_tgt = id_pc + {id_imm[61:0], 2'b00};

`ifdef STATIC_BTFN_PREDICT_EN
    assign pred = br_pred;
    assign idp  = run & id_valid & id_is_cb & id_imm[63] & ~stall & ~mis;
    logic unused_bits;
    assign unused_bits = ^{br_imm[63:62], id_imm[62]};
`else
    assign pred = 1'b0;
    assign idp  = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{br_pred, id_valid, id_is_cb, id_imm[63:62], br_imm[63:62]};
`endif

    always_comb begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
        pc_d          = (state_q == BOOT) ? pc_q :
                        mis   ? (taken ? br_tgt : br_pc + 64'd4) :
                        stall ? pc_q :
                        idp   ? id_tgt : pc_q + 64'd4;
        br_cnt_d      = (run & br_valid & ~&br_cnt_q) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
        mis_cnt_d     = (mis & ~&mis_cnt_q) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
        flush         = mis ? 3'b111 : {2'b00, idp};
        id_pred_taken = idp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign pc            = pc_q;
    assign fetch_valid   = fetch_valid_q;
    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized and directed check of pc_sequencer against a behavioural model
module tb_pc_sequencer;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n, stall, br_valid, br_uncond, br_cbz, br_cbnz, br_zero, br_pred;
    logic id_valid, id_is_cb;
    logic [63:0] br_pc, br_imm, id_pc, id_imm;
    logic [63:0] pc;
    logic fetch_valid, id_pred_taken;
    logic [2:0] flush;
    logic [CNT_W-1:0] br_count, mispred_count;

    int total = 0;
    int bad = 0;

    logic [63:0] m_pc;
    bit m_fv, m_boot;
    int m_bc, m_mc;

    pc_sequencer #(.RESET_PC(64'h0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
        .br_uncond(br_uncond), .br_cbz(br_cbz), .br_cbnz(br_cbnz),
        .br_zero(br_zero), .br_pred(br_pred), .br_pc(br_pc), .br_imm(br_imm),
        .id_valid(id_valid), .id_is_cb(id_is_cb), .id_pc(id_pc), .id_imm(id_imm),
        .pc(pc), .fetch_valid(fetch_valid), .id_pred_taken(id_pred_taken),
        .flush(flush), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall = 0; br_valid = 0; br_uncond = 0; br_cbz = 0; br_cbnz = 0;
        br_zero = 0; br_pred = 0; br_pc = 0; br_imm = 0;
        id_valid = 0; id_is_cb = 0; id_pc = 0; id_imm = 0;
    endtask

    // Checks comb outputs mid-cycle, advances the model over one edge, then checks state.
    task automatic step();
        bit run, taken, pred, mis, idp;
        logic [2:0] fl;
        run   = rst_n && !m_boot;
        taken = br_uncond || (br_cbz && br_zero) || (br_cbnz && !br_zero);
`ifdef STATIC_BTFN_PREDICT_EN
        pred = br_pred;
        idp  = run && id_valid && id_is_cb && id_imm[63] && !stall && !(br_valid && (taken != pred));
`else
        pred = 0;
        idp  = 0;
`endif
        mis = run && br_valid && (taken != pred);
        fl  = mis ? 3'b111 : idp ? 3'b001 : 3'b000;
        #3;
        chk("flush", flush, fl);
        chk("id_pred", id_pred_taken, idp);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_pc = 64'h0; m_fv = 0; m_boot = 1; m_bc = 0; m_mc = 0;
        end else if (m_boot) begin
            m_boot = 0; m_fv = 1;
        end else begin
            if (br_valid && m_bc < MAXC) m_bc++;
            if (mis && m_mc < MAXC) m_mc++;
            if (mis) m_pc = taken ? br_pc + br_imm * 4 : br_pc + 4;
            else if (!stall) m_pc = idp ? id_pc + id_imm * 4 : m_pc + 4;
        end
        chk("pc", pc, m_pc);
        chk("fetch_valid", fetch_valid, m_fv);
        chk("br_count", br_count, 64'(m_bc));
        chk("mispred_count", mispred_count, 64'(m_mc));
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
        step();
    endtask

    initial begin
        logic [31:0] r;
        m_pc = 0; m_fv = 0; m_boot = 1; m_bc = 0; m_mc = 0;
        idle();
        rst_n = 0;
        step();
        step();
        chk("rst_pc", pc, 64'h0);
        chk("rst_fv", fetch_valid, 0);
        rst_n = 1;
        step();
        chk("boot_pc", pc, 64'h0);
        chk("run_fv", fetch_valid, 1);
        step();
        chk("seq_pc", pc, 64'h4);

        br_valid = 1; br_uncond = 1; br_pc = 64'h100; br_imm = -64'sd2;
        #3 chk("b_flush", flush, 3'b111);
        step();
        chk("b_target", pc, 64'hF8);
        chk("b_mis", mispred_count, 1);
        idle();
        br_valid = 1; br_cbz = 1; br_zero = 0; br_pc = 64'h40;
        step();
        chk("cbz_pc", pc, 64'hFC);
        chk("cbz_mis", mispred_count, 1);
        idle();

        do_reset();
        repeat (8) step();
        chk("pre_stall", pc, 64'h20);
        stall = 1;
        repeat (3) step();
        chk("stall_hold", pc, 64'h20);
        br_valid = 1; br_uncond = 1; br_pc = 64'h200; br_imm = 64'd3;
        step();
        chk("stall_mis", pc, 64'h20C);
        idle();

`ifdef STATIC_BTFN_PREDICT_EN
        id_valid = 1; id_is_cb = 1; id_pc = 64'h80; id_imm = -64'sd4;
        step();
        chk("btfn_target", pc, 64'h70);
        idle();
        br_valid = 1; br_cbnz = 1; br_zero = 1; br_pred = 1; br_pc = 64'h80;
        step();
        chk("btfn_recover", pc, 64'h84);
        idle();
`endif

        br_valid = 1; br_uncond = 1; br_pc = 64'h300; rst_n = 0;
        step();
        chk("rst_mid_redirect", pc, 64'h0);
        idle();
        rst_n = 1;
        step();

        do_reset();
        br_valid = 1; br_uncond = 1;
        repeat (20) step();
        chk("sat_mis", mispred_count, 64'(MAXC));
        chk("sat_br", br_count, 64'(MAXC));
        idle();

        repeat (400) begin
            rst_n     = ($urandom % 60) != 0;
            stall     = ($urandom % 4) == 0;
            br_valid  = ($urandom % 3) == 0;
            br_uncond = $urandom % 2;
            br_cbz    = $urandom % 2;
            br_cbnz   = $urandom % 2;
            br_zero   = $urandom % 2;
            br_pred   = $urandom % 2;
            br_pc     = {$urandom, $urandom};
            r         = $urandom;
            br_imm    = {{32{r[31]}}, r};
            id_valid  = $urandom % 2;
            id_is_cb  = $urandom % 2;
            id_pc     = {$urandom, $urandom};
            r         = $urandom;
            id_imm    = {{32{r[31]}}, r};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
